gbm_path_stepper: RTL



---
 rtl/gbm_path_stepper_if.sv | 43 ++++
 rtl/gbm_path_stepper.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gbm_path_stepper_if.sv
// Stream bundle between the path stepper and its neighbours: normal draws in,
// GBM request/result, and the tagged price stream out to LSM storage.
interface gbm_path_stepper_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 1,
    parameter int unsigned PW    = 1
);
    logic             z_valid;
    logic             z_ready;
    logic [WIDTH-1:0] z;

    logic             gbm_valid;
    logic             gbm_ready;
    logic [WIDTH-1:0] gbm_z;
    logic [WIDTH-1:0] gbm_S;
    logic [WIDTH-1:0] gbm_r;
    logic [WIDTH-1:0] gbm_sigma;
    logic [WIDTH-1:0] gbm_dt;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_S;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_S;
    logic [SW-1:0]    out_step;
    logic [PW-1:0]    out_path;
    logic             out_last_step;
    logic             out_last;

    modport master (
        input  z_valid, z, gbm_ready, res_valid, res_S, out_ready,
        output z_ready, gbm_valid, gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt,
               res_ready, out_valid, out_S, out_step, out_path, out_last_step, out_last
    );

    modport slave (
        output z_valid, z, gbm_ready, res_valid, res_S, out_ready,
        input  z_ready, gbm_valid, gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt,
               res_ready, out_valid, out_S, out_step, out_path, out_last_step, out_last
    );
endinterface

// File: rtl/gbm_path_stepper.sv
// Path-simulation sequencer: feeds one draw plus the current price to the GBM stage,
// feeds each result back as the next price and emits it tagged with path/step indices.
module gbm_path_stepper #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned QFRAC   = 16,
    parameter int unsigned N_STEPS = 50,
    parameter int unsigned N_PATHS = 1024,
    parameter int unsigned SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    parameter int unsigned PW      = (N_PATHS > 1) ? $clog2(N_PATHS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   S0,
    input  logic [WIDTH-1:0]   r,
    input  logic [WIDTH-1:0]   sigma,
    input  logic [WIDTH-1:0]   dt,
    output logic               busy,
    output logic               done,
    output logic               neg_clamp,
    gbm_path_stepper_if.master bus
);

    if (N_STEPS < 1 || N_PATHS < 1 || QFRAC >= WIDTH) begin : g_bad_cfg
        $error("gbm_path_stepper: invalid parameterisation");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_FLUSH, S_DONE
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);
    localparam logic [PW-1:0] LAST_PATH = PW'(N_PATHS - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] s_cur, s0_q, r_q, sigma_q, dt_q;
    logic [SW-1:0]    step;
    logic [PW-1:0]    path;
    logic             last_step, last_path, fire, res_neg;
    logic [WIDTH-1:0] res_clamped;

    assign last_step   = (step == LAST_STEP);
    assign last_path   = (path == LAST_PATH);
    assign fire        = bus.z_valid && bus.gbm_ready;
    assign res_neg     = bus.res_S[WIDTH-1];
    assign res_clamped = res_neg ? '0 : bus.res_S;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.z_ready   = 1'b0;
        bus.gbm_valid = 1'b0;
        bus.gbm_z     = '0;
        bus.gbm_S     = '0;
        bus.gbm_r     = '0;
        bus.gbm_sigma = '0;
        bus.gbm_dt    = '0;
        bus.res_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_ISSUE;
            S_ISSUE: begin
                bus.gbm_valid = bus.z_valid;
                bus.z_ready   = bus.gbm_ready;
                bus.gbm_z     = bus.z;
                bus.gbm_S     = s_cur;
                bus.gbm_r     = r_q;
                bus.gbm_sigma = sigma_q;
                bus.gbm_dt    = dt_q;
                // A request that fires together with abort still owes us one result.
                if (abort)     state_n = fire ? S_FLUSH : S_IDLE;
                else if (fire) state_n = S_WAIT;
            end
            S_WAIT: begin
                bus.res_ready = 1'b1;
                // Result taken in the abort cycle itself: nothing left to flush.
                if (abort)              state_n = bus.res_valid ? S_IDLE : S_FLUSH;
                else if (bus.res_valid) state_n = S_EMIT;
            end
            S_EMIT: begin
                bus.out_valid = 1'b1;
                if (abort) state_n = S_IDLE;
                else if (bus.out_ready)
                    state_n = (last_step && last_path) ? S_DONE : S_ISSUE;
            end
            S_FLUSH: begin
                bus.res_ready = 1'b1;
                if (bus.res_valid) state_n = S_IDLE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cur             <= '0;
            s0_q              <= '0;
            r_q               <= '0;
            sigma_q           <= '0;
            dt_q              <= '0;
            step              <= '0;
            path              <= '0;
            neg_clamp         <= 1'b0;
            bus.out_S         <= '0;
            bus.out_step      <= '0;
            bus.out_path      <= '0;
            bus.out_last_step <= 1'b0;
            bus.out_last      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    s0_q      <= S0;
                    r_q       <= r;
                    sigma_q   <= sigma;
                    dt_q      <= dt;
                    s_cur     <= S0;
                    step      <= '0;
                    path      <= '0;
                    neg_clamp <= 1'b0;
                end
                S_WAIT: if (bus.res_valid && !abort) begin
                    s_cur             <= res_clamped;
                    bus.out_S         <= res_clamped;
                    bus.out_step      <= step;
                    bus.out_path      <= path;
                    bus.out_last_step <= last_step;
                    bus.out_last      <= last_step && last_path;
                    if (res_neg) neg_clamp <= 1'b1;
                end
                S_EMIT: if (bus.out_ready && !abort) begin
                    if (last_step) begin
                        step  <= '0;
                        s_cur <= s0_q;
                        if (!last_path) path <= path + PW'(1);
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
